// File: rtl/bg_model_update.sv
// Per-pixel running-Gaussian background model kept in external SRAM.
// Each accepted pixel is read, updated and written back over a fixed 6-cycle walk.
module bg_model_update #(
    parameter int H_MAX     = 640,
    parameter int V_MAX     = 480,
    parameter int PIX_W     = 10,
    parameter int ADDR_W    = 20,
    parameter int ADDR_BASE = 0,
    parameter int ALPHA     = 4,
    parameter int VAR_INIT  = 64,
    parameter int VAR_MIN   = 16,
    parameter int TH_K      = 36
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sof,
    input  logic [PIX_W-1:0]  i_r,
    input  logic [PIX_W-1:0]  i_g,
    input  logic [PIX_W-1:0]  i_b,
    input  logic [1:0]        i_mode,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_rd,
    output logic              o_sram_wr,
    output logic [15:0]       o_sram_wdata,
    input  logic [15:0]       i_sram_rdata,
    output logic              o_fg,
    output logic              o_fg_valid,
    output logic [7:0]        o_gray,
    output logic              o_frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_RD_MEAN, S_RD_VAR, S_CALC, S_WR_MEAN, S_WR_VAR} state_t;

    localparam int NPIX = H_MAX * V_MAX;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int GW   = PIX_W + 7;
    localparam logic [PW-1:0]        PIX_LAST = PW'(NPIX - 1);
    localparam logic signed [17:0]   VMIN     = 18'(VAR_MIN);
    localparam logic signed [17:0]   VMAX     = 18'sd65535;

    state_t             state, state_nx;
    logic [PW-1:0]      pix;
    logic               init_done;
    logic [7:0]         gray_q;
    logic [1:0]         mode_q;
    logic [15:0]        mean_q, var_q, mean_new, var_new;
    logic [GW-1:0]      gsum;
    logic [7:0]         gray_c;
    logic               mem_en;
    logic [ADDR_W-1:0]  mean_addr;

    assign gsum      = GW'(38) * GW'(i_r) + GW'(75) * GW'(i_g) + GW'(15) * GW'(i_b);
    assign gray_c    = 8'(gsum >> (PIX_W - 1));
    // FREEZE only takes effect once the model holds a full frame
    assign mem_en    = !(init_done && mode_q[1]);
    assign mean_addr = ADDR_W'(ADDR_BASE) + ADDR_W'({pix, 1'b0});

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        o_ready      = 1'b0;
        o_sram_rd    = 1'b0;
        o_sram_wr    = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_fg_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nx = S_RD_MEAN;
            end
            S_RD_MEAN: begin
                o_sram_rd   = mem_en;
                o_sram_addr = mean_addr;
                state_nx    = S_RD_VAR;
            end
            S_RD_VAR: begin
                o_sram_rd   = mem_en;
                o_sram_addr = mean_addr + 1'b1;
                state_nx    = S_CALC;
            end
            S_CALC: state_nx = S_WR_MEAN;
            S_WR_MEAN: begin
                o_sram_wr    = mem_en;
                o_sram_addr  = mean_addr;
                o_sram_wdata = mean_new;
                o_fg_valid   = 1'b1;
                state_nx     = S_WR_VAR;
            end
            S_WR_VAR: begin
                o_sram_wr    = mem_en;
                o_sram_addr  = mean_addr + 1'b1;
                o_sram_wdata = var_new;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    logic signed [8:0]  d;
    logic signed [17:0] dx, dsq, mdiff, msum, vdiff, vsum;
    logic [15:0]        d2, mean_c, var_c;
    logic [23:0]        fg_lhs, fg_rhs;
    logic               fg_c;

    always_comb begin
        d      = $signed({1'b0, gray_q}) - $signed({1'b0, mean_q[15:8]});
        dx     = {{9{d[8]}}, d};
        dsq    = dx * dx;
        d2     = dsq[15:0];
        mdiff  = $signed({2'b00, gray_q, 8'h00}) - $signed({2'b00, mean_q});
        msum   = $signed({2'b00, mean_q}) + (mdiff >>> ALPHA);
        vdiff  = $signed({2'b00, d2}) - $signed({2'b00, var_q});
        vsum   = $signed({2'b00, var_q}) + (vdiff >>> ALPHA);
        mean_c = msum[15:0];
        if (vsum < VMIN)      var_c = 16'(VAR_MIN);
        else if (vsum > VMAX) var_c = 16'hFFFF;
        else                  var_c = vsum[15:0];
        fg_lhs = {6'b0, d2, 2'b00};
        fg_rhs = 24'(var_q) * 24'(TH_K);
        fg_c   = fg_lhs > fg_rhs;
        // until a full frame has been seen the SRAM contents are meaningless
        if (!init_done) begin
            mean_c = {gray_q, 8'h00};
            var_c  = 16'(VAR_INIT);
            fg_c   = 1'b0;
        end
        if (mode_q == 2'd0) fg_c = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix          <= '0;
            init_done    <= 1'b0;
            gray_q       <= '0;
            mode_q       <= '0;
            mean_q       <= '0;
            var_q        <= '0;
            mean_new     <= '0;
            var_new      <= '0;
            o_fg         <= 1'b0;
            o_gray       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                S_IDLE: if (i_valid) begin
                    gray_q <= gray_c;
                    mode_q <= i_mode;
                    if (i_sof) pix <= '0;
                end
                S_RD_MEAN: mean_q <= i_sram_rdata;
                S_RD_VAR:  var_q  <= i_sram_rdata;
                S_CALC: begin
                    mean_new <= mean_c;
                    var_new  <= var_c;
                    o_fg     <= fg_c;
                    o_gray   <= gray_q;
                end
                S_WR_VAR: begin
                    if (pix == PIX_LAST) begin
                        pix          <= '0;
                        init_done    <= 1'b1;
                        o_frame_done <= 1'b1;
                    end else begin
                        pix <= pix + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bg_model_update.md
BG_MODEL_UPDATE -- requirements
Module: bg_model_update

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- H_MAX, 640: pixels per line.
- V_MAX, 480: lines per frame.
- PIX_W, 10: bits per colour channel.
- ADDR_W, 20: SRAM address width.
- ADDR_BASE, 0: first SRAM word of the model.
- ALPHA, 4: learning-rate shift.
- VAR_INIT, 64: first-frame variance.
- VAR_MIN, 16: variance floor.
- TH_K, 36: foreground threshold factor (4*diff^2 vs var*TH_K).
REQ-002 Ports, one per line (name, direction, width, meaning); clocking is one clock, reset synchronous and active-high:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_valid, in, 1: pixel valid.
- o_ready, out, 1: pixel accepted when i_valid & o_ready.
- i_sof, in, 1: accepted pixel is (0,0).
- i_r, i_g, i_b, in, PIX_W each: colour.
- i_mode, in, 2: 0 LEARN, 1 DETECT, 2/3 FREEZE.
- o_sram_addr, out, ADDR_W: word address.
- o_sram_rd, out, 1: read strobe.
- o_sram_wr, out, 1: write strobe.
- o_sram_wdata, out, 16: write data.
- i_sram_rdata, in, 16: read data, valid in the same cycle as o_sram_rd.
- o_fg, out, 1: foreground flag.
- o_fg_valid, out, 1: o_fg/o_gray valid pulse.
- o_gray, out, 8: pixel grayscale.
- o_frame_done, out, 1: one-cycle pulse after the last pixel of a frame.

Function
REQ-003 FSM states and transitions: S_IDLE -> S_RD_MEAN -> S_RD_VAR -> S_CALC -> S_WR_MEAN -> S_WR_VAR -> S_IDLE, one cycle each; the pixel is accepted in S_IDLE; 6 cycles per pixel minimum.
REQ-004 o_ready = 1 only in S_IDLE; i_valid is ignored in all other states.
REQ-005 On acceptance, gray and i_mode are registered:
- gray = (38*r + 75*g + 15*b) >> (PIX_W-1), truncated to 8 bits.
- The intermediate product is PIX_W+7 bits wide, with no overflow.
REQ-006 Pixel index p counts 0..H_MAX*V_MAX-1. An accepted pixel with i_sof=1 uses p=0, regardless of the counter.
REQ-007 SRAM word layout:
- mean word at ADDR_BASE+2p, unsigned 8.8 fixed point;
- var word at ADDR_BASE+2p+1, unsigned 16-bit integer.
REQ-008 Read phase: S_RD_MEAN drives o_sram_rd=1 with the mean address and captures i_sram_rdata; S_RD_VAR does the same for the var word.
REQ-009 S_CALC arithmetic (registered):
- m = mean[15:8].
- d = gray - m, 9-bit signed.
- d2 = d*d, 16 bits.
- mean_new = mean + (((gray<<8) - mean) >>> ALPHA), signed arithmetic.
- var_new = var + ((d2 - var) >>> ALPHA), clamped to [VAR_MIN, 65535].
- fg = (4*d2 > var*TH_K); comparison in 24-bit unsigned arithmetic.
REQ-010 First-frame rule: while init_done=0, read data is ignored; mean_new = gray<<8, var_new = VAR_INIT, fg = 0.
REQ-011 Write phase: S_WR_MEAN writes mean_new and S_WR_VAR writes var_new, with o_sram_wr=1.
REQ-012 In FREEZE mode o_sram_wr stays 0, o_sram_rd stays 0 and the FSM still walks all states; FREEZE with init_done=0 behaves as LEARN.
REQ-013 In LEARN mode o_fg is forced to 0.
REQ-014 o_fg_valid pulses in S_WR_MEAN (4 cycles after the acceptance edge), with o_fg and o_gray stable in that cycle; o_fg and o_gray hold until the next pulse.
REQ-015 Strobe rules: o_sram_rd and o_sram_wr are never both high; both are 0 in S_IDLE and S_CALC.
REQ-016 In S_WR_VAR the pixel advances to p+1; when p = H_MAX*V_MAX-1 it instead wraps to 0, sets init_done=1 and pulses o_frame_done in the next cycle (S_IDLE).
REQ-017 An i_sof pixel arriving while p≠0 does not pulse o_frame_done and does not set init_done.

Reset
REQ-018 i_rst=1 at a clock edge returns to S_IDLE from any state, including mid-write; the aborted pixel is not advanced.
REQ-019 Reset values:
- p = 0, init_done = 0;
- o_ready = 1;
- o_sram_rd = 0, o_sram_wr = 0, o_sram_addr = 0, o_sram_wdata = 0;
- o_fg = 0, o_fg_valid = 0, o_gray = 0, o_frame_done = 0.

Verification
REQ-020 Bench parameters H_MAX=4, V_MAX=2, PIX_W=10, defaults otherwise. Directed scenarios:
- Reset: hold i_rst for 2 cycles -> o_ready=1, all other outputs 0; reset asserted in S_WR_MEAN -> o_sram_wr=0 next cycle, p unchanged.
- First frame: LEARN, r=g=b=1023 -> o_gray=255, writes addr0=0xFF00, addr1=0x0040, o_fg=0; o_fg_valid 4 cycles after acceptance.
- Stable pixel: DETECT, frame 2, mean=0xFF00, var=64, gray 255 -> o_fg=0, writes 0xFF00 and 60.
- Foreground: DETECT, mean=0x6400, var=64, r=g=b=803 (gray 200) -> o_fg=1, writes 0x6A40 and 685.
- Floor/freeze: var=16, d=0 -> writes 16 (clamp); FREEZE with the same stimulus -> o_sram_wr and o_sram_rd never 1, o_fg still valid.
- Wrap/sof: 8 pixels -> o_frame_done one pulse, next pixel addr 0; i_sof on 3rd pixel -> addresses 0/1, no o_frame_done.
